// File: rtl/matrix_entry_ctrl_if.sv
// Signal bundle between matrix_entry_ctrl and its keypad scanner, operand file and multiplier.
// master = controller side, slave = environment side.
interface matrix_entry_ctrl_if #(
  parameter int unsigned DATA_W = 8
);
  logic              read_input;
  logic [3:0]        keypad_input;
  logic [2:0]        operator_input;
  logic              equal_input;
  logic              key_read;
  logic              wr_en;
  logic [2:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              mult_start;
  logic              mult_done;
  logic              busy;
  logic              err;
  logic [2:0]        entry_idx;
  logic [DATA_W-1:0] entry_value;
  logic [2:0]        ctrl_state;

  modport master (
    input  read_input, keypad_input, operator_input, equal_input, mult_done,
    output key_read, wr_en, wr_addr, wr_data, mult_start, busy, err,
           entry_idx, entry_value, ctrl_state
  );

  modport slave (
    output read_input, keypad_input, operator_input, equal_input, mult_done,
    input  key_read, wr_en, wr_addr, wr_data, mult_start, busy, err,
           entry_idx, entry_value, ctrl_state
  );
endinterface

// File: rtl/matrix_entry_ctrl.sv
// Keypad-to-operand sequencer for the 2x2 matrix multiplier: decimal entry, commit, start, wait.
// Optional macro SIGNED_ENTRY_EN adds a minus-key sign toggle and two's complement entries.
module matrix_entry_ctrl #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned DONE_TIMEOUT = 1024
) (
  input logic                 clk,
  input logic                 rst,
  matrix_entry_ctrl_if.master bus_io
);
  localparam int unsigned CntW = $clog2(DONE_TIMEOUT + 1);
  localparam int unsigned AccW = DATA_W + 4;
`ifdef SIGNED_ENTRY_EN
  localparam logic [AccW-1:0] MaxMag = {{(AccW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
`else
  localparam logic [AccW-1:0] MaxMag = {{(AccW-DATA_W){1'b0}}, {DATA_W{1'b1}}};
`endif
  localparam logic [2:0] OpMinus = 3'b001;
  localparam logic [2:0] OpPlus  = 3'b010;
  localparam logic [2:0] OpSub   = 3'b011;
  localparam logic [2:0] OpMul   = 3'b100;

  typedef enum logic [2:0] {
    StEntry    = 3'd0,
    StStart    = 3'd1,
    StWaitDone = 3'd2,
    StShow     = 3'd3
  } state_e;

  state_e            state_q, state_d;
  logic              arm_q, arm_d;
  logic              key_read_q, key_read_d;
  logic              wr_en_q, wr_en_d;
  logic [2:0]        wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              mult_start_q, mult_start_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [2:0]        idx_q, idx_d;
  logic [DATA_W-1:0] mag_q, mag_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
`ifdef SIGNED_ENTRY_EN
  logic              sign_q, sign_d;
`endif

  logic            digit_ev, nd_raw, nd_ev, eq_ev, op_ev, commit;
  logic [AccW-1:0] acc;

  always_comb begin
    digit_ev = bus_io.read_input;
    nd_raw   = (bus_io.operator_input != 3'b000) || bus_io.equal_input;
    nd_ev    = nd_raw && arm_q;
    // A digit wins the cycle; a coinciding non-digit key keeps arm and is taken next cycle.
    eq_ev    = !digit_ev && nd_ev && bus_io.equal_input;
    op_ev    = !digit_ev && nd_ev && !bus_io.equal_input;
    acc      = ({4'b0000, mag_q} * AccW'(10)) + {{DATA_W{1'b0}}, bus_io.keypad_input};

    state_d      = state_q;
    arm_d        = arm_q;
    key_read_d   = digit_ev || nd_ev;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    mult_start_d = 1'b0;
    err_d        = err_q;
    idx_d        = idx_q;
    mag_d        = mag_q;
    cnt_d        = cnt_q;
    commit       = 1'b0;
`ifdef SIGNED_ENTRY_EN
    sign_d       = sign_q;
`endif

    if (nd_ev && !digit_ev) begin
      arm_d = 1'b0;
    end else if (!nd_raw) begin
      arm_d = 1'b1;
    end

    case (state_q)
      StEntry: begin
        if (digit_ev) begin
          mag_d = (acc > MaxMag) ? MaxMag[DATA_W-1:0] : acc[DATA_W-1:0];
        end else if (eq_ev) begin
          if (idx_q == 3'd7) begin
            commit  = 1'b1;
            state_d = StStart;
          end
        end else if (op_ev) begin
          case (bus_io.operator_input)
            OpPlus: commit = (idx_q != 3'd7);
            OpSub: begin
              mag_d = '0;
`ifdef SIGNED_ENTRY_EN
              sign_d = 1'b0;
`endif
            end
            OpMul: begin
              idx_d = 3'd0;
              mag_d = '0;
`ifdef SIGNED_ENTRY_EN
              sign_d = 1'b0;
`endif
            end
`ifdef SIGNED_ENTRY_EN
            OpMinus: sign_d = !sign_q;
`endif
            default: ;
          endcase
        end
      end
      StStart: begin
        mult_start_d = 1'b1;
        cnt_d        = '0;
        state_d      = StWaitDone;
      end
      StWaitDone: begin
        if (bus_io.mult_done) begin
          state_d = StShow;
        end else if (cnt_q == CntW'(DONE_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StShow;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StShow: begin
        // The key only dismisses the result; its own action is dropped.
        if (digit_ev || nd_ev) begin
          err_d   = 1'b0;
          idx_d   = 3'd0;
          mag_d   = '0;
          state_d = StEntry;
`ifdef SIGNED_ENTRY_EN
          sign_d  = 1'b0;
`endif
        end
      end
      default: state_d = StEntry;
    endcase

    if (commit) begin
      wr_en_d   = 1'b1;
      wr_addr_d = idx_q;
      wr_data_d = val_q;
      idx_d     = idx_q + 3'd1;
      mag_d     = '0;
`ifdef SIGNED_ENTRY_EN
      sign_d    = 1'b0;
`endif
    end

`ifdef SIGNED_ENTRY_EN
    val_d = sign_d ? ({DATA_W{1'b0}} - mag_d) : mag_d;
`else
    val_d = mag_d;
`endif
    busy_d = (state_d == StStart) || (state_d == StWaitDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StEntry;
      arm_q        <= 1'b1;
      key_read_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 3'd0;
      wr_data_q    <= '0;
      mult_start_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      idx_q        <= 3'd0;
      mag_q        <= '0;
      val_q        <= '0;
      cnt_q        <= '0;
`ifdef SIGNED_ENTRY_EN
      sign_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      arm_q        <= arm_d;
      key_read_q   <= key_read_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      mult_start_q <= mult_start_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      idx_q        <= idx_d;
      mag_q        <= mag_d;
      val_q        <= val_d;
      cnt_q        <= cnt_d;
`ifdef SIGNED_ENTRY_EN
      sign_q       <= sign_d;
`endif
    end
  end

  assign bus_io.key_read    = key_read_q;
  assign bus_io.wr_en       = wr_en_q;
  assign bus_io.wr_addr     = wr_addr_q;
  assign bus_io.wr_data     = wr_data_q;
  assign bus_io.mult_start  = mult_start_q;
  assign bus_io.busy        = busy_q;
  assign bus_io.err         = err_q;
  assign bus_io.entry_idx   = idx_q;
  assign bus_io.entry_value = val_q;
  assign bus_io.ctrl_state  = state_q;
endmodule

// File: doc/matrix_entry_ctrl.md
Name: matrix_entry_ctrl

Overview:
Sequences keypad events from the keypad scanner into the eight operands of the 2x2 x 2x2 multiplier: A00,A01,A10,A11,B00,B01,B10,B11.
Accumulates multi-digit decimal entries and commits each to the operand register file. Starts the multiplier, waits for completion with a timeout, then holds the result for display.
Acts as the general controller for the scanner's read_input/key_read handshake.

Parameters:
DATA_W, 8, operand width in bits; the entry accumulator saturates at this width.
DONE_TIMEOUT, 1024, maximum cycles in WAIT_DONE before the error flag is set.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
read_input  in  1  one-cycle pulse from the scanner: a digit key is valid
keypad_input  in  4  digit value 0-9, valid with read_input
operator_input  in  3  level from scanner: 001 minus, 010 plus, 011 subtract, 100 multiply, 000 none
equal_input  in  1  level from scanner: equals key
key_read  out  1  one-cycle acknowledge to the scanner
wr_en  out  1  operand write strobe
wr_addr  out  3  operand index 0-7 (A row-major, then B row-major)
wr_data  out  DATA_W  committed operand value
mult_start  out  1  one-cycle multiplier start pulse
mult_done  in  1  multiplier completion pulse or level
busy  out  1  high in START and WAIT_DONE
err  out  1  sticky timeout flag
entry_idx  out  3  operand index currently being entered
entry_value  out  DATA_W  live accumulator value, for display
ctrl_state  out  3  current state encoding, for FPGA debug

Behaviour:
- Reset (async, rst=1): state=ENTRY; key_read, wr_en, mult_start, busy and err=0; entry_idx=0; entry_value=0; wr_addr=0; wr_data=0; internal arm flag=1.
- States: ENTRY=0, START=1, WAIT_DONE=2, SHOW=3.
- Event detection, evaluated every cycle:
  - Digit event: read_input=1.
  - Non-digit event: (operator_input!=0 or equal_input=1) and arm=1.
  - On a non-digit event: arm is cleared. Arm is set again only on a cycle where operator_input=0 and equal_input=0.
  - Priority when events coincide: digit > equal > operator. A non-digit event that loses to a digit stays pending, because arm is unchanged.
- Every accepted event produces key_read=1 for exactly one cycle, on the clock edge after detection, in every state. This keeps the scanner from stalling.
- ENTRY state:
  - Digit: entry_value <= min(entry_value*10 + digit, 2^DATA_W-1). Computed at DATA_W+4 bits, then saturated. Updates on the same edge as key_read.
  - Plus (010):
    - If entry_idx<7: wr_en=1 for one cycle, wr_addr=entry_idx, wr_data=entry_value; then entry_idx+1 and entry_value=0.
    - If entry_idx=7: acknowledged only, no write.
  - Subtract (011): entry_value <= 0. Backspace-to-zero; no write.
  - Multiply (100): abort. entry_idx=0, entry_value=0, no writes. Operands already written are stale but harmless.
  - Equal:
    - If entry_idx=7: write entry 7 as for plus, then go to START.
    - If entry_idx<7: acknowledged only, no state change.
- START: mult_start=1 for exactly one cycle, busy=1, timeout counter=0; go to WAIT_DONE.
- WAIT_DONE:
  - Key events are acknowledged but ignored.
  - mult_done=1: go to SHOW.
  - Counter reaches DONE_TIMEOUT without mult_done: set err=1 and go to SHOW.
  - If mult_done arrives on the timeout cycle, it wins and err stays 0.
- SHOW: operands and result are held. Any accepted event clears err, sets entry_idx=0 and entry_value=0, and returns to ENTRY; the event's own action is not applied.
- wr_en and mult_start are never high in the same cycle. All outputs are registered.

Optional Feature:
SIGNED_ENTRY_EN:
- Defined:
  - Minus (001) in ENTRY toggles a sign bit for the current entry.
  - entry_value and wr_data are two's complement, and the magnitude saturates at 2^(DATA_W-1)-1.
  - The sign is cleared on commit, subtract, abort and reset.
- Undefined: minus is acknowledged with no effect, and values are unsigned.

Test Plan:
- Digits 1,2 then plus -> two key_read pulses with entry_value=1 then 12; plus -> wr_en with wr_addr=0, wr_data=12, entry_idx=1, entry_value=0.
- DATA_W=8; digits 9,9,9 -> entry_value 9, 99, 255 (saturated); plus -> wr_data=255.
- Equal at entry_idx=3 -> key_read pulse, no write, state stays ENTRY. Operator held 5000 cycles -> exactly one key_read.
- Eight entries 1..8 separated by plus, final equal -> writes to addresses 0..7 with values 1..8; mult_start one cycle after the addr-7 write; mult_done after 20 cycles -> SHOW with err=0; next digit -> ENTRY, entry_idx=0.
- DONE_TIMEOUT=16 with mult_done held 0 -> SHOW after 16 WAIT_DONE cycles with err=1; key press -> err=0.
- Reset asserted mid-entry at entry_idx=5, entry_value=42 -> all outputs return to reset values asynchronously; a digit after release is accepted normally.
